// File: rtl/alu_pkg.sv
// alu_pkg: ALUControl encodings shared by the ALU decoder and the execute unit,
// plus the execute-unit FSM state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/alu_shift_seq.sv
// alu_shift_seq: iterative logical shifter, one bit per clock. A started shift
// of n>=1 asserts o_done on its n-th busy cycle with the final value on o_result.
module alu_shift_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_abort,
    input  logic               i_start,
    input  logic               i_dir,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic [WIDTH-1:0]   i_data,
    output logic               o_busy,
    output logic               o_done,
    output logic [WIDTH-1:0]   o_result
);

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_acc;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_dir;
    logic [WIDTH-1:0]   w_step;

    // r_dir=1 is srl (ALUControl[0]); both directions zero-fill.
    assign w_step   = r_dir ? (r_acc >> 1) : (r_acc << 1);
    assign o_busy   = (r_state == ST_SHIFT);
    assign o_done   = o_busy && (r_cnt == SHAMT_W'(1));
    assign o_result = w_step;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
        end else if (i_abort) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (i_start) begin
            r_state <= ST_SHIFT;
            r_acc   <= i_data;
            r_cnt   <= i_shamt;
            r_dir   <= i_dir;
        end else if (r_state == ST_SHIFT) begin
            r_acc <= w_step;
            r_cnt <= r_cnt - SHAMT_W'(1);
            if (r_cnt == SHAMT_W'(1)) begin
                r_state <= ST_IDLE;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32 execute-stage ALU with valid/ready on both sides and a
// registered result. Define ALU_BARREL_SHIFT_EN for single-cycle shifts.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;

    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_diff;
    logic               w_slt;
    logic [WIDTH-1:0]   w_alu_result;
    logic               w_accept;
    logic               w_unit_idle;
    logic               w_fast_load;
    logic               w_shift_done;
    logic [WIDTH-1:0]   w_shift_result;

    assign w_shamt = SrcB[SHAMT_W-1:0];
    assign w_diff  = SrcA - SrcB;
    // Signed less-than: sign of A-B corrected by its overflow.
    assign w_slt   = w_diff[WIDTH-1] ^ ((SrcA[WIDTH-1] ^ SrcB[WIDTH-1]) &
                                        (w_diff[WIDTH-1] ^ SrcA[WIDTH-1]));

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        w_alu_result = SrcA + SrcB;
        case (ALUControl)
            ALU_SUB: w_alu_result = w_diff;
            ALU_AND: w_alu_result = SrcA & SrcB;
            ALU_OR:  w_alu_result = SrcA | SrcB;
            ALU_XOR: w_alu_result = SrcA ^ SrcB;
            ALU_SLT: w_alu_result = {{(WIDTH-1){1'b0}}, w_slt};
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL: w_alu_result = SrcA << w_shamt;
            ALU_SRL: w_alu_result = SrcA >> w_shamt;
`else
            // Only the shamt==0 case completes here; longer shifts go iterative.
            ALU_SLL: w_alu_result = SrcA;
            ALU_SRL: w_alu_result = SrcA;
`endif
            default: w_alu_result = SrcA + SrcB;
        endcase
    end

`ifdef ALU_BARREL_SHIFT_EN
    assign w_unit_idle    = 1'b1;
    assign w_fast_load    = w_accept;
    assign w_shift_done   = 1'b0;
    assign w_shift_result = '0;
`else
    logic w_is_shift;
    logic w_shift_busy;

    assign w_is_shift  = (ALUControl == ALU_SLL) || (ALUControl == ALU_SRL);
    assign w_fast_load = w_accept && !(w_is_shift && (w_shamt != '0));
    assign w_unit_idle = !w_shift_busy;

    alu_shift_seq #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shift_seq (
        .clk      (clk),
        .rst      (rst),
        .i_abort  (flush),
        .i_start  (w_accept && !w_fast_load),
        .i_dir    (ALUControl[0]),
        .i_shamt  (w_shamt),
        .i_data   (SrcA),
        .o_busy   (w_shift_busy),
        .o_done   (w_shift_done),
        .o_result (w_shift_result)
    );
`endif

    assign in_ready = !rst && w_unit_idle && (!r_out_valid || out_ready) && !flush;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_fast_load) begin
            r_result    <= w_alu_result;
            r_zero      <= (w_alu_result == '0);
            r_out_valid <= 1'b1;
        end else if (w_shift_done) begin
            r_result    <= w_shift_result;
            r_zero      <= (w_shift_result == '0);
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign ALUResult = r_result;
    assign Zero      = r_zero;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int W = 32;
`ifdef ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   ALUControl;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALUResult;
    logic         Zero;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model: holds the visible result, and a countdown for a pending shift result.
    bit           m_valid    = 1'b0;
    logic [W-1:0] m_res      = '0;
    int           m_left     = 0;
    logic [W-1:0] m_pend     = '0;
    bit           m_acc_last = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, want 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [2:0] ctl, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (ctl)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            ALU_SLL: return a << b[$clog2(W)-1:0];
            default: return a >> b[$clog2(W)-1:0];
        endcase
    endfunction

    function automatic bit model_ready();
        return !rst && (m_left == 0) && (!m_valid || out_ready) && !flush;
    endfunction

    always @(posedge clk) begin : model
        bit           acc;
        bit           nv;
        logic [W-1:0] nr;
        logic [W-1:0] np;
        logic [W-1:0] r;
        int           nl;
        acc = in_valid && model_ready();
        nv  = m_valid;
        nr  = m_res;
        nl  = m_left;
        np  = m_pend;
        if (rst) begin
            nv = 1'b0; nr = '0; nl = 0;
        end else if (flush) begin
            nv = 1'b0; nl = 0;
        end else begin
            if (out_ready) nv = 1'b0;
            if (nl > 0) begin
                nl--;
                if (nl == 0) begin nv = 1'b1; nr = np; end
            end
            if (acc) begin
                r = ref_op(ALUControl, SrcA, SrcB);
                if (!BARREL && (ALUControl == ALU_SLL || ALUControl == ALU_SRL) &&
                    SrcB[$clog2(W)-1:0] != '0) begin
                    nl = int'(SrcB[$clog2(W)-1:0]);
                    np = r;
                end else begin
                    nv = 1'b1; nr = r;
                end
            end
        end
        m_valid    <= nv;
        m_res      <= nr;
        m_left     <= nl;
        m_pend     <= np;
        m_acc_last <= acc;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("in_ready", W'(in_ready), W'(model_ready()));
            check("out_valid", W'(out_valid), W'(m_valid));
            if (m_valid) begin
                check("result", ALUResult, m_res);
                check("zero", W'(Zero), W'(m_res == '0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [2:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        in_valid = 1'b1; ALUControl = ctl; SrcA = a; SrcB = b;
        do begin
            tick();
            n++;
        end while (!m_acc_last && n < 100);
        if (!m_acc_last) begin
            errors++;
            $display("FAIL accept_timeout: op %0d not accepted within %0d cycles", ctl, n);
        end
        in_valid = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lat;
        int seen;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ALUControl = '0; SrcA = '0; SrcB = '0;
        tick();
        cmp_en = 1'b1;
        @(negedge clk);
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_result", ALUResult, W'(0));
        check("rst_zero", W'(Zero), W'(0));
        check("rst_in_ready", W'(in_ready), W'(0));
        tick();
        rst = 1'b0;

        send(ALU_ADD, 5, 7);
        @(negedge clk);
        check("add_result", ALUResult, 12);
        check("add_zero", W'(Zero), W'(0));
        check("add_valid", W'(out_valid), W'(1));
        #1;
        send(ALU_SUB, 32'h10, 32'h10);
        @(negedge clk);
        check("sub_result", ALUResult, 0);
        check("sub_zero", W'(Zero), W'(1));
        #1;
        send(ALU_SLT, 32'hFFFF_FFFF, 1);
        @(negedge clk);
        check("slt_neg_lt", ALUResult, 1);
        #1;
        send(ALU_SLT, 1, 32'hFFFF_FFFF);
        @(negedge clk);
        check("slt_pos_ge", ALUResult, 0);
        check("slt_zero", W'(Zero), W'(1));
        #1;

        send(ALU_SLL, 1, 5);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("sll_latency", W'(lat), BARREL ? W'(0) : W'(5));
        check("sll_result", ALUResult, 32'h20);

        // Backpressure: result must hold and a waiting op must not slip in.
        send(ALU_OR, 32'hF0, 32'h0F);
        out_ready = 1'b0;
        in_valid = 1'b1; ALUControl = ALU_XOR; SrcA = 3; SrcB = 5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_result", ALUResult, 32'hFF);
            check("hold_valid", W'(out_valid), W'(1));
            check("hold_in_ready", W'(in_ready), W'(0));
        end
        #1;
        out_ready = 1'b1;
        #1;
        check("release_in_ready", W'(in_ready), W'(1));
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("release_new_result", ALUResult, 32'h6);
        check("release_new_valid", W'(out_valid), W'(1));
        #1;

        // Flush three cycles after accepting a long shift.
        send(ALU_SRL, 32'h8000_0000, 31);
        tick();
        tick();
        flush = 1'b1; in_valid = 1'b1; ALUControl = ALU_ADD; SrcA = 1; SrcB = 1;
        @(negedge clk);
        check("flush_in_ready", W'(in_ready), W'(0));
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("post_flush_ready", W'(in_ready), W'(1));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_no_result", W'(seen), W'(0));
        #1;

        // Same again, killed by reset.
        send(ALU_SRL, 32'h8000_0000, 31);
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("midshift_rst_ready", W'(in_ready), W'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midshift_rst_valid", W'(out_valid), W'(0));
        check("midshift_rst_result", ALUResult, W'(0));
        check("midshift_rst_zero", W'(Zero), W'(0));
        check("midshift_rst_in_ready", W'(in_ready), W'(1));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_no_result", W'(seen), W'(0));

        tick();
        for (int c = 0; c < 4000; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            flush      = ($urandom_range(0, 49) == 0);
            out_ready  = ($urandom_range(0, 9) < 7);
            in_valid   = ($urandom_range(0, 9) < 6);
            ALUControl = 3'($urandom_range(0, 7));
            SrcA       = $urandom;
            SrcB       = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : $urandom;
            if ($urandom_range(0, 7) == 0) SrcB = SrcA;
            tick();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (40) tick();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
